// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Contents: shift op encodings, FSM state type, default datapath sizes and a
//   helper that sizes the stage-index counter.
package cpu_shift_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_SHAMT_BITS = 5;

  localparam logic OP_SLL = 1'b0;  // shift left, zero fill
  localparam logic OP_SRA = 1'b1;  // arithmetic shift right, sign fill

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to hold a stage index 0..n-1 (at least one bit).
  function automatic int stage_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_stage_var.sv
// One selectable logarithmic shift stage: shifts by 2**(SHAMT_BITS-1-k) when enabled.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: value/result are the data in and out; k picks the stage; enable gates the
//   shift; dir selects SLL (zero fill) or SRA (fill from value MSB).
module shift_stage_var
  import cpu_shift_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SHAMT_BITS = DEF_SHAMT_BITS,
  parameter int K_BITS     = stage_idx_bits(SHAMT_BITS)
) (
  input  logic [WIDTH-1:0]  value,
  input  logic [K_BITS-1:0] k,
  input  logic              enable,
  input  logic              dir,
  output logic [WIDTH-1:0]  result
);

  // One-hot shift amount: stage k moves by 2**(SHAMT_BITS-1-k), so bit
  // (SHAMT_BITS-1-k) of the amount is the only one set.
  logic [SHAMT_BITS-1:0] amt;

  always_comb begin
    amt = '0;
    for (int i = 0; i < SHAMT_BITS; i++) begin
      if (int'(k) == SHAMT_BITS - 1 - i) begin
        amt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    result = value;
    if (enable) begin
      case (dir)
        OP_SLL:  result = value << amt;
        OP_SRA:  result = $unsigned($signed(value) >>> amt);
        default: result = value;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA unit: applies stages 16,8,4,2,1 one per clock to a working register.
// Latency: fixed SHAMT_BITS cycles from accepted start to the one-cycle data_resultRDY pulse.
// Backpressure: starts accepted only in IDLE or DONE; a start during SHIFT is dropped, not queued.
// Ports: clock/reset (async, active-high); ctrl_start/ctrl_op/ctrl_shiftamt/data_operandA
//   form the request; data_result is the working register, valid when data_resultRDY
//   pulses and held until the next accepted start; busy is high during SHIFT.
module shift_sequencer
  import cpu_shift_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SHAMT_BITS = DEF_SHAMT_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_start,
  input  logic                  ctrl_op,
  input  logic [WIDTH-1:0]      data_operandA,
  input  logic [SHAMT_BITS-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]      data_result,
  output logic                  data_resultRDY,
  output logic                  busy
);

  localparam int K_BITS = stage_idx_bits(SHAMT_BITS);

  generate
    if (WIDTH != (2 ** SHAMT_BITS)) begin : g_bad_width
      $error("shift_sequencer: WIDTH must equal 2**SHAMT_BITS");
    end
  endgenerate

  state_t                state;
  logic [K_BITS-1:0]     k_q;
  logic [SHAMT_BITS-1:0] shamt_q;
  logic                  op_q;
  logic [WIDTH-1:0]      work;
  logic                  rdy_q;
  logic                  busy_q;

  logic                  stage_en;
  logic [WIDTH-1:0]      stage_out;

  // Stage k consumes the shift-amount bits MSB first.
  always_comb begin
    stage_en = 1'b0;
    for (int i = 0; i < SHAMT_BITS; i++) begin
      if (int'(k_q) == i) begin
        stage_en = shamt_q[SHAMT_BITS-1-i];
      end
    end
  end

  shift_stage_var #(
    .WIDTH      (WIDTH),
    .SHAMT_BITS (SHAMT_BITS),
    .K_BITS     (K_BITS)
  ) u_stage (
    .value  (work),
    .k      (k_q),
    .enable (stage_en),
    .dir    (op_q),
    .result (stage_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      k_q     <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
      work    <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (ctrl_start) begin
            work    <= data_operandA;
            shamt_q <= ctrl_shiftamt;
            op_q    <= ctrl_op;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            // DONE lasts one cycle; the result stays in work.
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Every stage is visited even when its bit is clear, so latency is fixed.
          work <= stage_out;
          if (k_q == K_BITS'(SHAMT_BITS - 1)) begin
            k_q    <= '0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = work;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_op;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int total  = 0;
  int passed = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: the shift defined arithmetically on the whole word.
  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] a, input int sh);
    logic [31:0] r;
    if (op) r = $unsigned($signed(a) >>> sh);
    else    r = a << sh;
    return r;
  endfunction

  // Drives one request and observes the following 20 cycles.
  task automatic issue(input logic op, input logic [31:0] a, input logic [4:0] sh, input bit jitter,
                       output logic [31:0] res, output int lat, output int rdy_cnt, output int busy_bad);
    res = '0; lat = 0; rdy_cnt = 0; busy_bad = 0;
    ctrl_start = 1'b1; ctrl_op = op; data_operandA = a; ctrl_shiftamt = sh;
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (jitter && c <= 5) begin
        data_operandA = $urandom;
        ctrl_shiftamt = 5'($urandom);
        ctrl_op       = 1'($urandom);
      end else begin
        data_operandA = '0; ctrl_shiftamt = '0; ctrl_op = 1'b0;
      end
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (lat == 0) begin
          lat = c;
          res = data_result;
        end
      end
      if (c < 5 && busy !== 1'b1) busy_bad++;
      if (c >= 5 && busy !== 1'b0) busy_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_start = 1'b0; ctrl_op = 1'b0; data_operandA = '0; ctrl_shiftamt = '0;
    @(posedge clock); #1;
    total++; if (data_result !== 32'h0) $display("FAIL reset_result got %h exp %h", data_result, 32'h0); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b exp 0", data_resultRDY); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t        v[6];
    logic [31:0] res;
    int          lat, rc, bb;
    v[0] = '{1'b1, 32'h80000000, 5'd16, 32'hFFFF8000};
    v[1] = '{1'b0, 32'h00000001, 5'd31, 32'h80000000};
    v[2] = '{1'b1, 32'hF0000000, 5'd4,  32'hFF000000};
    v[3] = '{1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    v[4] = '{1'b0, 32'h12345678, 5'd0,  32'h12345678};
    v[5] = '{1'b1, 32'h12345678, 5'd0,  32'h12345678};
    for (int i = 0; i < 6; i++) begin
      issue(v[i].op, v[i].a, v[i].sh, 1'b0, res, lat, rc, bb);
      total++; if (res !== v[i].exp) $display("FAIL dir%0d_result got %h exp %h", i, res, v[i].exp); else passed++;
      total++; if (lat !== 5) $display("FAIL dir%0d_latency got %0d exp 5", i, lat); else passed++;
      total++; if (rc !== 1) $display("FAIL dir%0d_rdy_pulses got %0d exp 1", i, rc); else passed++;
      total++; if (bb !== 0) $display("FAIL dir%0d_busy_profile got %0d bad cycles exp 0", i, bb); else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    int          rc, lat;
    logic [31:0] res;
    rc = 0; lat = 0; res = '0;
    ctrl_start = 1'b1; ctrl_op = 1'b1; data_operandA = 32'h80000000; ctrl_shiftamt = 5'd16;
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        ctrl_start = 1'b1; ctrl_op = 1'b0; data_operandA = 32'hDEADBEEF; ctrl_shiftamt = 5'd4;
      end
      if (c == 3) begin
        ctrl_start = 1'b0; data_operandA = '0; ctrl_shiftamt = '0;
      end
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) begin
        rc++;
        if (lat == 0) begin lat = c; res = data_result; end
      end
    end
    total++; if (res !== 32'hFFFF8000) $display("FAIL busy_start_result got %h exp %h", res, 32'hFFFF8000); else passed++;
    total++; if (rc !== 1) $display("FAIL busy_start_pulses got %0d exp 1", rc); else passed++;
    total++; if (lat !== 5) $display("FAIL busy_start_latency got %0d exp 5", lat); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int          rc, mid_bad;
    r1 = '0; r2 = '0; rc = 0; mid_bad = 0;
    ctrl_start = 1'b1; ctrl_op = 1'b0; data_operandA = 32'h00000003; ctrl_shiftamt = 5'd4;
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) begin
        ctrl_start = 1'b1; ctrl_op = 1'b1; data_operandA = 32'h80000010; ctrl_shiftamt = 5'd4;
      end
      if (c == 7) begin
        ctrl_start = 1'b0; data_operandA = $urandom; ctrl_shiftamt = 5'($urandom); ctrl_op = 1'b0;
      end
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) rc++;
      if (c == 5) r1 = data_result;
      if (c == 11) r2 = data_result;
      if (c == 6 && (data_resultRDY !== 1'b0 || busy !== 1'b1)) mid_bad++;
      if (c == 11 && data_resultRDY !== 1'b1) mid_bad++;
    end
    total++; if (r1 !== 32'h00000030) $display("FAIL b2b_first got %h exp %h", r1, 32'h00000030); else passed++;
    total++; if (r2 !== 32'hF8000001) $display("FAIL b2b_second got %h exp %h", r2, 32'hF8000001); else passed++;
    total++; if (rc !== 2) $display("FAIL b2b_pulses got %0d exp 2", rc); else passed++;
    total++; if (mid_bad !== 0) $display("FAIL b2b_timing got %0d bad samples exp 0", mid_bad); else passed++;
  endtask

  task automatic test_reset_abort();
    int          rc, lat, bb;
    logic [31:0] res;
    rc = 0;
    ctrl_start = 1'b1; ctrl_op = 1'b0; data_operandA = 32'hA5A5A5A5; ctrl_shiftamt = 5'd3;
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else passed++;
    total++; if (data_resultRDY !== 1'b0) $display("FAIL abort_rdy got %b exp 0", data_resultRDY); else passed++;
    total++; if (data_result !== 32'h0) $display("FAIL abort_result got %h exp %h", data_result, 32'h0); else passed++;
    @(posedge clock); #3;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) rc++;
    end
    total++; if (rc !== 0) $display("FAIL abort_no_rdy got %0d pulses exp 0", rc); else passed++;
    issue(1'b0, 32'h0000000F, 5'd8, 1'b0, res, lat, rc, bb);
    total++; if (res !== 32'h00000F00) $display("FAIL post_reset_result got %h exp %h", res, 32'h00000F00); else passed++;
    total++; if (lat !== 5) $display("FAIL post_reset_latency got %0d exp 5", lat); else passed++;
  endtask

  task automatic test_random();
    logic        op;
    logic [31:0] a, res, exp;
    logic [4:0]  sh;
    int          lat, rc, bb;
    for (int i = 0; i < 30; i++) begin
      op  = 1'($urandom);
      a   = $urandom;
      sh  = 5'($urandom_range(0, 31));
      exp = ref_shift(op, a, int'(sh));
      issue(op, a, sh, 1'b1, res, lat, rc, bb);
      total++;
      if (res !== exp)
        $display("FAIL rand%0d_result op=%b a=%h sh=%0d got %h exp %h", i, op, a, sh, res, exp);
      else passed++;
      total++;
      if (lat !== 5 || rc !== 1 || bb !== 0)
        $display("FAIL rand%0d_timing got lat=%0d pulses=%0d busy_bad=%0d exp 5/1/0", i, lat, rc, bb);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
